memory_port_arbiter: RTL
========================

# memory_port_arbiter

Shares the single unified memory port between instruction fetch and the Memory stage's load/store path. It accepts one request at a time, drives the external memory request/handshake, and returns read data, load-valid and store-complete pulses to the originating requester. It sits between the Fetch/Memory pipeline stages and the memory/bus interface, with at most one transaction outstanding.

## Interface
- DATA_PRIORITY, 1: on simultaneous requests, 1 = data side wins, 0 = fetch side wins (fixed-priority mode only)
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- fetchRequest  in  1  fetch wants the word at fetchAddress
- fetchAddress  in  32  fetch address, word aligned
- fetchFlush  in  1  discard any fetch in flight; no fetchValid for it
- fetchData  out  32  instruction word; valid with fetchValid
- fetchValid  out  1  one-cycle pulse
- loadRequest  in  1  Memory stage load (readEnable, legal, not flushed)
- storeRequest  in  1  Memory stage storeValid
- dataAddress  in  32  load/store address
- storeData  in  32  lane-shifted store data
- storeByteEnable  in  4  lane byte enables
- loadData  out  32  raw load word; valid with loadDataValid
- loadDataValid  out  1  one-cycle pulse
- storeComplete  out  1  one-cycle pulse
- memRequest  out  1  request to memory; held until memReady
- memWrite  out  1  1 = write
- memAddress  out  32  request address
- memWriteData  out  32  write data
- memByteEnable  out  4  write lanes; 4'b1111 for reads
- memReady  in  1  memory accepts request this cycle
- memResponseValid  in  1  read data / write ack this cycle
- memReadData  in  32  read data

## Operation
- FSM: IDLE, ISSUE, WAIT. Owner register: FETCH or DATA.
- IDLE: choose a winner among fetchRequest and data (loadRequest or storeRequest); latch address, write flag, data, and byte enables into output registers; go to ISSUE. Never both load and store: if both are set, store wins.
- ISSUE: memRequest=1. On memReady, go to WAIT. If memReady and memResponseValid arrive in the same cycle, complete directly.
- WAIT: on memResponseValid, register the result, pulse the owner's output, and return to IDLE.
- A fetch owner with fetchFlush seen at any point from grant to response is marked dropped. The transaction still completes on the bus, but fetchValid is suppressed. fetchFlush in IDLE has no effect.
- Data transactions are never aborted.
- Requesters must drop their request the cycle after the valid/complete pulse. A still-high request is treated as new and re-issued.
- Outputs change only on clock edges; there are no combinational paths from memory inputs to requester outputs.

## Timing
- Reset: state IDLE, owner FETCH, memRequest 0, memWrite 0, memAddress 0, memWriteData 0, memByteEnable 0, all pulses 0, fetchData 0, loadData 0, dropped flag 0.
- Request seen in IDLE at cycle N drives memRequest high at N+1.
- Response at cycle M gives the pulse and data at M+1. The arbiter is in IDLE at M+1, so the next grant is issued at M+2.
- Minimum latency with memReady and memResponseValid in the same cycle: request N → pulse N+2.
- Reset mid-transaction: immediately returns to IDLE. A late memResponseValid in IDLE is ignored.
- memResponseValid in IDLE or in ISSUE without memReady is ignored.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: a last-winner bit alternates grants when both sides request, and DATA_PRIORITY is ignored. Resets to FETCH so the first contention goes to data.
- Undefined: fixed priority per DATA_PRIORITY. Fetch may starve under back-to-back data traffic.

## Structure
- Shared package: arbiter state enum (ARB_IDLE, ARB_ISSUE, ARB_WAIT) and owner enum (OWNER_FETCH, OWNER_DATA).
- Single module. Grant selection is natural as the sub-module memory_grant_select (combinational, contains the round-robin bit logic under the macro).

## Test plan
- Lone fetch, addr 0x100, memReady=1 at once, response 0x00500093 two cycles later → fetchValid with fetchData=0x00500093. No loadDataValid.
- Simultaneous fetch 0x200 and load 0x1004, fixed priority (DATA_PRIORITY=1) → load issued first with memByteEnable 4'b1111; loadDataValid precedes fetchValid. Fetch is issued the cycle after the load pulse + 1.
- Store 0x2002, byte enables 4'b1100, data 0xABCD0000 → memWrite=1 with matching byte enables and data; write ack → storeComplete is a single-cycle pulse.
- fetchFlush during WAIT → bus response consumed, fetchValid stays 0, next request is granted normally.
- memReady held low for 5 cycles → memRequest and its address/data/byte-enables stay stable throughout. Reset asserted in WAIT → all outputs return to reset values next cycle.
- MEM_ARB_ROUND_ROBIN_EN, fetch and load both held continuously → grants alternate DATA, FETCH, DATA, FETCH.

Source files
------------

// File: rtl/memory_port_arbiter_pkg.sv
// memory_port_arbiter_pkg
//   Shared definitions for the unified memory port arbiter: FSM state
//   encodings, transaction owner type and the fixed read byte-enable value.
//   Imported by memory_port_arbiter and memory_grant_select.
package memory_port_arbiter_pkg;

    // Arbiter FSM state encodings (kept as plain constants for older tools).
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ARB_IDLE  = 2'd0;
    localparam arb_state_t ARB_ISSUE = 2'd1;
    localparam arb_state_t ARB_WAIT  = 2'd2;

    // Which requester owns the transaction currently on the bus.
    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_t;

    // Reads always request the full word.
    localparam logic [3:0] READ_BYTE_ENABLE = 4'b1111;

endpackage

// File: rtl/memory_grant_select.sv
// memory_grant_select
//   Combinational winner selection between the fetch side and the data
//   (load/store) side of the memory port arbiter.
//   Config macro: MEM_ARB_ROUND_ROBIN_EN -- when defined, contention is
//   resolved by alternating against last_winner and DATA_PRIORITY is ignored;
//   when undefined, DATA_PRIORITY gives fixed priority.
// Ports:
//   fetch_request  in   fetch side is asking for the port
//   data_request   in   load or store is asking for the port
//   last_winner    in   previous grant owner (round-robin build only)
//   any_request    out  at least one side is requesting
//   winner         out  side that gets the port if a grant happens
module memory_grant_select
    import memory_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_PRIORITY = 1
) (
    input  logic   fetch_request,
    input  logic   data_request,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  owner_t last_winner,
`endif
    output logic   any_request,
    output owner_t winner
);

    // Pick the winner; only contention needs a policy decision.
    always_comb begin
        any_request = fetch_request | data_request;
        winner      = OWNER_FETCH;
        if (fetch_request && data_request) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            // Give the port to whichever side did not win last time.
            if (last_winner == OWNER_FETCH) begin
                winner = OWNER_DATA;
            end else begin
                winner = OWNER_FETCH;
            end
`else
            if (DATA_PRIORITY != 0) begin
                winner = OWNER_DATA;
            end else begin
                winner = OWNER_FETCH;
            end
`endif
        end else if (data_request) begin
            winner = OWNER_DATA;
        end else begin
            winner = OWNER_FETCH;
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
//   Shares one unified memory port between instruction fetch and the Memory
//   stage load/store path, with at most one transaction outstanding.
//   All requester-facing outputs are registered; there is no combinational
//   path from memory inputs to requester outputs.
//   Config macro: MEM_ARB_ROUND_ROBIN_EN (round-robin arbitration on
//   contention; default build uses fixed priority from DATA_PRIORITY).
// Ports:
//   clock, reset                          synchronous active-high reset
//   fetchRequest/fetchAddress/fetchFlush  fetch request side
//   fetchData/fetchValid                  fetch result, one-cycle pulse
//   loadRequest/storeRequest/dataAddress/storeData/storeByteEnable
//                                         Memory stage request side
//   loadData/loadDataValid/storeComplete  data results, one-cycle pulses
//   memRequest/memWrite/memAddress/memWriteData/memByteEnable
//                                         registered memory request
//   memReady/memResponseValid/memReadData memory handshake and response
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_PRIORITY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetchRequest,
    input  logic [31:0] fetchAddress,
    input  logic        fetchFlush,
    output logic [31:0] fetchData,
    output logic        fetchValid,
    input  logic        loadRequest,
    input  logic        storeRequest,
    input  logic [31:0] dataAddress,
    input  logic [31:0] storeData,
    input  logic [3:0]  storeByteEnable,
    output logic [31:0] loadData,
    output logic        loadDataValid,
    output logic        storeComplete,
    output logic        memRequest,
    output logic        memWrite,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic [3:0]  memByteEnable,
    input  logic        memReady,
    input  logic        memResponseValid,
    input  logic [31:0] memReadData
);

    arb_state_t state_r;
    owner_t     owner_r;
    logic       dropped_r;
    logic       grant_any_s;
    owner_t     grant_winner_s;
    logic       grant_s;
    logic       complete_s;
    logic       flush_hit_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t     last_winner_r;
`endif

    memory_grant_select #(
        .DATA_PRIORITY (DATA_PRIORITY)
    ) u_grant_select (
        .fetch_request (fetchRequest),
        .data_request  (loadRequest | storeRequest),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_winner   (last_winner_r),
`endif
        .any_request   (grant_any_s),
        .winner        (grant_winner_s)
    );

    // Decode grant, completion and flush-hit events for the current cycle.
    always_comb begin
        grant_s     = 1'b0;
        complete_s  = 1'b0;
        flush_hit_s = 1'b0;
        if (state_r == ARB_IDLE) begin
            grant_s = grant_any_s;
        end else begin
            grant_s = 1'b0;
        end
        if (state_r == ARB_ISSUE) begin
            // Ready and response together finish without visiting WAIT.
            complete_s = memReady & memResponseValid;
        end else if (state_r == ARB_WAIT) begin
            complete_s = memResponseValid;
        end else begin
            complete_s = 1'b0;
        end
        // A flush only matters while a fetch owns an active transaction.
        if ((state_r != ARB_IDLE) && (owner_r == OWNER_FETCH)) begin
            flush_hit_s = fetchFlush;
        end else begin
            flush_hit_s = 1'b0;
        end
    end

    // FSM state and the memRequest handshake line.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ARB_IDLE;
            memRequest <= 1'b0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (grant_s) begin
                        state_r    <= ARB_ISSUE;
                        memRequest <= 1'b1;
                    end else begin
                        state_r    <= ARB_IDLE;
                        memRequest <= 1'b0;
                    end
                end
                ARB_ISSUE: begin
                    if (complete_s) begin
                        state_r    <= ARB_IDLE;
                        memRequest <= 1'b0;
                    end else if (memReady) begin
                        state_r    <= ARB_WAIT;
                        memRequest <= 1'b0;
                    end else begin
                        state_r    <= ARB_ISSUE;
                        memRequest <= 1'b1;
                    end
                end
                ARB_WAIT: begin
                    if (complete_s) begin
                        state_r <= ARB_IDLE;
                    end else begin
                        state_r <= ARB_WAIT;
                    end
                    memRequest <= 1'b0;
                end
                default: begin
                    state_r    <= ARB_IDLE;
                    memRequest <= 1'b0;
                end
            endcase
        end
    end

    // Latch owner and request fields at grant; they stay stable until the next grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_r       <= OWNER_FETCH;
            memWrite      <= 1'b0;
            memAddress    <= 32'h0000_0000;
            memWriteData  <= 32'h0000_0000;
            memByteEnable <= 4'b0000;
        end else if (grant_s) begin
            owner_r <= grant_winner_s;
            if (grant_winner_s == OWNER_DATA) begin
                memAddress <= dataAddress;
                // A simultaneous load and store is illegal upstream; store wins.
                if (storeRequest) begin
                    memWrite      <= 1'b1;
                    memWriteData  <= storeData;
                    memByteEnable <= storeByteEnable;
                end else begin
                    memWrite      <= 1'b0;
                    memWriteData  <= 32'h0000_0000;
                    memByteEnable <= READ_BYTE_ENABLE;
                end
            end else begin
                memAddress    <= fetchAddress;
                memWrite      <= 1'b0;
                memWriteData  <= 32'h0000_0000;
                memByteEnable <= READ_BYTE_ENABLE;
            end
        end else begin
            owner_r <= owner_r;
        end
    end

    // Dropped flag: set by any flush seen while a fetch is in flight, cleared on grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            dropped_r <= 1'b0;
        end else if (grant_s) begin
            dropped_r <= 1'b0;
        end else if (flush_hit_s) begin
            dropped_r <= 1'b1;
        end else begin
            dropped_r <= dropped_r;
        end
    end

    // Registered result data and one-cycle completion pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetchData     <= 32'h0000_0000;
            fetchValid    <= 1'b0;
            loadData      <= 32'h0000_0000;
            loadDataValid <= 1'b0;
            storeComplete <= 1'b0;
        end else begin
            fetchValid    <= 1'b0;
            loadDataValid <= 1'b0;
            storeComplete <= 1'b0;
            if (complete_s) begin
                if (owner_r == OWNER_FETCH) begin
                    // A flush in the response cycle itself also drops the fetch.
                    if (!dropped_r && !fetchFlush) begin
                        fetchValid <= 1'b1;
                        fetchData  <= memReadData;
                    end else begin
                        fetchValid <= 1'b0;
                    end
                end else if (memWrite) begin
                    storeComplete <= 1'b1;
                end else begin
                    loadDataValid <= 1'b1;
                    loadData      <= memReadData;
                end
            end else begin
                fetchValid <= 1'b0;
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remember the last grant owner; starts at FETCH so first contention goes to data.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_winner_r <= OWNER_FETCH;
        end else if (grant_s) begin
            last_winner_r <= grant_winner_s;
        end else begin
            last_winner_r <= last_winner_r;
        end
    end
`endif

endmodule
